leaf_node_interface: RTL

Network endpoint at a leaf of the quadtree. It is the far end of the parent router's child port, using the same valid/data/credit protocol the root node drives downstream. It buffers incoming flits, executes write and read-request flits against a local register-file memory, and returns read-response flits upstream under credit-based backpressure.

---
 rtl/leaf_node_interface.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/leaf_node_interface.sv
// Leaf endpoint of the quadtree network.
// Buffers flits arriving from the parent router, applies writes and read
// requests to a local register-file memory, and returns read responses
// upstream under credit-based flow control.
module leaf_node_interface #(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int FLIT_W      = 2 + ADDR_W + DATA_W,
    parameter int BUF_DEPTH   = 4,
    parameter int CREDIT_INIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_data_valid,
    input  logic [FLIT_W-1:0] in_data,
    output logic              upstream_credit,
    output logic              out_data_valid,
    output logic [FLIT_W-1:0] out_data,
    input  logic              downstream_credit,
    output logic              err
);

    localparam int BUF_AW    = $clog2(BUF_DEPTH);
    localparam int PTR_W     = BUF_AW + 1;
    localparam int CNT_W     = $clog2(CREDIT_INIT + 1);
    localparam int MEM_DEPTH = 1 << ADDR_W;

    localparam logic [1:0] TYPE_WR   = 2'b01;
    localparam logic [1:0] TYPE_RD   = 2'b10;
    localparam logic [1:0] TYPE_RESP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Storage
    logic [FLIT_W-1:0] fifo_mem_r [BUF_DEPTH];
    logic [DATA_W-1:0] mem_r      [MEM_DEPTH];

    // Registered state
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  credit_cnt_r;
    logic              upstream_credit_r;
    logic              out_valid_r;
    logic [FLIT_W-1:0] out_data_r;
    logic              err_r;

    // Combinational helpers
    logic [PTR_W-1:0]  fill_s;
    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              drop_s;
    logic [FLIT_W-1:0] head_s;
    logic [1:0]        head_type_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic              pop_s;
    logic              mem_we_s;
    logic              bad_type_s;
    logic              send_s;
    logic [CNT_W-1:0]  credit_next_s;
    logic              credit_ovf_s;
    state_t            state_next_s;
    logic              valid_next_s;

    // Fullness is judged before any same-cycle pop, so a push into a full
    // FIFO is dropped even when the head leaves in that cycle.
    assign fill_s      = wr_ptr_r - rd_ptr_r;
    assign empty_s     = (fill_s == {PTR_W{1'b0}});
    assign full_s      = (fill_s == PTR_W'(BUF_DEPTH));
    assign push_s      = in_data_valid & ~full_s;
    assign drop_s      = in_data_valid & full_s;

    assign head_s      = fifo_mem_r[rd_ptr_r[BUF_AW-1:0]];
    assign head_type_s = head_s[FLIT_W-1 -: 2];
    assign head_addr_s = head_s[DATA_W +: ADDR_W];
    assign head_data_s = head_s[DATA_W-1:0];

    // Only IDLE consumes flits, which keeps at most one read in flight.
    assign pop_s       = (state_r == ST_IDLE) & ~empty_s;
    assign mem_we_s    = pop_s & (head_type_s == TYPE_WR) & rst;
    assign bad_type_s  = pop_s & ((head_type_s == 2'b00) | (head_type_s == TYPE_RESP));

    // A response that is valid this cycle is accepted by the parent this cycle.
    assign send_s      = out_valid_r;

    // Credit counter update: send and return cancel; a surplus return saturates.
    always_comb begin
        credit_next_s = credit_cnt_r;
        credit_ovf_s  = 1'b0;
        case ({send_s, downstream_credit})
            2'b10: begin
                credit_next_s = credit_cnt_r - CNT_W'(1);
            end
            2'b01: begin
                if (credit_cnt_r == CNT_W'(CREDIT_INIT)) begin
                    credit_ovf_s = 1'b1;
                end else begin
                    credit_next_s = credit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                credit_next_s = credit_cnt_r;
            end
        endcase
    end

    // Main FSM next state: IDLE pops, RD reads memory, RESP waits for credit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s && (head_type_s == TYPE_RD)) begin
                    state_next_s = ST_RD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (send_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Valid is registered from next-cycle state and credit so a returned
    // credit in one cycle releases a stalled response in the following one.
    assign valid_next_s = (state_next_s == ST_RESP) && (credit_next_s != {CNT_W{1'b0}});

    // Input FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[BUF_AW-1:0]] <= in_data;
        end
    end

    // Local register-file memory, deliberately preserved across reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[head_addr_s] <= head_data_s;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // FSM state register and latched read address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (pop_s && (head_type_s == TYPE_RD)) begin
                addr_r <= head_addr_s;
            end
        end
    end

    // Response path: memory read in RD lands directly in the output register
    // and is held unchanged for as long as RESP stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_r  <= {FLIT_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (state_r == ST_RD) begin
                out_data_r <= {TYPE_RESP, addr_r, mem_r[addr_r]};
            end
            out_valid_r <= valid_next_s;
        end
    end

    // Transmit credits, upstream credit pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_cnt_r      <= CNT_W'(CREDIT_INIT);
            upstream_credit_r <= 1'b0;
            err_r             <= 1'b0;
        end else begin
            credit_cnt_r      <= credit_next_s;
            upstream_credit_r <= pop_s;
            err_r             <= err_r | drop_s | bad_type_s | credit_ovf_s;
        end
    end

    assign upstream_credit = upstream_credit_r;
    assign out_data_valid  = out_valid_r;
    assign out_data        = out_data_r;
    assign err             = err_r;

endmodule
